// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: turns SPI frames into address loads and memory accesses,
// returns read data to the slave and recovers from a silent memory.
module spi_ram_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int AUTO_INC = 0,
    parameter int TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [9:0]        rx_data,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [CNT_W-1:0]  wait_cnt;

    logic cmd_wa;
    logic cmd_wd;
    logic cmd_ra;
    logic cmd_rd;
    logic timed_out;

    assign cmd_wa = (rx_data[9:8] == 2'b00);
    assign cmd_wd = (rx_data[9:8] == 2'b01);
    assign cmd_ra = (rx_data[9:8] == 2'b10);
    assign cmd_rd = (rx_data[9:8] == 2'b11);

    // Abort at the end of the TIMEOUT-th unacknowledged request cycle.
    assign timed_out = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_addr   <= '0;
            rd_addr   <= '0;
            wait_cnt  <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (rx_valid) begin
                        unique case (1'b1)
                            cmd_wa: wr_addr <= rx_data[ADDR_W-1:0];
                            cmd_ra: rd_addr <= rx_data[ADDR_W-1:0];
                            cmd_wd: begin
                                mem_wdata <= rx_data[DATA_W-1:0];
                                mem_addr  <= wr_addr;
                                mem_we    <= 1'b1;
                                mem_req   <= 1'b1;
                                state     <= WR;
                            end
                            cmd_rd: begin
                                mem_addr <= rd_addr;
                                mem_we   <= 1'b0;
                                mem_req  <= 1'b1;
                                state    <= RD;
                            end
                        endcase
                    end
                end
                WR, RD: begin
                    if (rx_valid) begin
                        err <= 1'b1;
                    end
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        wait_cnt <= '0;
                        state    <= IDLE;
                        if (state == RD) begin
                            tx_data  <= mem_rdata;
                            tx_valid <= 1'b1;
                            if (AUTO_INC != 0) begin
                                rd_addr <= rd_addr + ADDR_W'(1);
                            end
                        end else if (AUTO_INC != 0) begin
                            wr_addr <= wr_addr + ADDR_W'(1);
                        end
                    end else if (timed_out) begin
                        mem_req  <= 1'b0;
                        err      <= 1'b1;
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl: directed checks of spi_ram_ctrl with a small
// acking memory (instance a) and a hand-driven timeout instance (b).
module tb_spi_ram_ctrl;

    logic       clk;
    logic       rst;
    logic [9:0] rx_data;

    logic       rx_valid_a;
    logic       tx_valid_a;
    logic [7:0] tx_data_a;
    logic       mem_req_a;
    logic       mem_we_a;
    logic [7:0] mem_addr_a;
    logic [7:0] mem_wdata_a;
    logic       mem_ack_a;
    logic [7:0] mem_rdata_a;
    logic       busy_a;
    logic       err_a;

    logic       rx_valid_b;
    logic       tx_valid_b;
    logic [7:0] tx_data_b;
    logic       mem_req_b;
    logic       mem_we_b;
    logic [7:0] mem_addr_b;
    logic [7:0] mem_wdata_b;
    logic       mem_ack_b;
    logic [7:0] mem_rdata_b;
    logic       busy_b;
    logic       err_b;

    logic       model_ack;
    logic       man_ack;
    logic       ack_en;
    int         ack_dly;
    int         dly_cnt;
    logic [7:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    spi_ram_ctrl #(
        .ADDR_W(8), .DATA_W(8), .AUTO_INC(1), .TIMEOUT(16)
    ) dut_a (
        .clk(clk), .rst(rst),
        .rx_valid(rx_valid_a), .rx_data(rx_data),
        .tx_valid(tx_valid_a), .tx_data(tx_data_a),
        .mem_req(mem_req_a), .mem_we(mem_we_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_ack(mem_ack_a), .mem_rdata(mem_rdata_a),
        .busy(busy_a), .err(err_a)
    );

    spi_ram_ctrl #(
        .ADDR_W(8), .DATA_W(8), .AUTO_INC(0), .TIMEOUT(4)
    ) dut_b (
        .clk(clk), .rst(rst),
        .rx_valid(rx_valid_b), .rx_data(rx_data),
        .tx_valid(tx_valid_b), .tx_data(tx_data_b),
        .mem_req(mem_req_b), .mem_we(mem_we_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_ack(mem_ack_b), .mem_rdata(mem_rdata_b),
        .busy(busy_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_ack_a = model_ack | man_ack;

    // Memory answers ack_dly+1 cycles after the request rises.
    always @(posedge clk) begin
        if (rst) begin
            model_ack <= 1'b0;
            dly_cnt   <= 0;
        end else begin
            model_ack <= 1'b0;
            if (ack_en && mem_req_a && !model_ack) begin
                if (dly_cnt == ack_dly) begin
                    model_ack <= 1'b1;
                    dly_cnt   <= 0;
                    if (mem_we_a) mem[mem_addr_a] <= mem_wdata_a;
                    mem_rdata_a <= mem[mem_addr_a];
                end else begin
                    dly_cnt <= dly_cnt + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [9:0] f);
        rx_data    = f;
        rx_valid_a = 1'b1;
        tick();
        rx_valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [9:0] f);
        rx_data    = f;
        rx_valid_b = 1'b1;
        tick();
        rx_valid_b = 1'b0;
    endtask

    function automatic logic [31:0] outs_a();
        return {3'b0, tx_valid_a, tx_data_a, mem_req_a, mem_we_a,
                mem_addr_a, mem_wdata_a, busy_a, err_a};
    endfunction

    function automatic logic [31:0] outs_b();
        return {3'b0, tx_valid_b, tx_data_b, mem_req_b, mem_we_b,
                mem_addr_b, mem_wdata_b, busy_b, err_b};
    endfunction

    initial begin
        logic       got_tx;
        logic       we_seen;
        logic [7:0] rd;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem_rdata_a = 8'h00;
        ack_en      = 1'b1;
        ack_dly     = 0;
        man_ack     = 1'b0;
        rx_valid_a  = 1'b0;
        rx_valid_b  = 1'b0;
        mem_ack_b   = 1'b0;
        mem_rdata_b = 8'h00;
        rx_data     = 10'h0;
        rst         = 1'b1;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            rx_data     = 10'($urandom);
            rx_valid_a  = 1'($urandom);
            rx_valid_b  = 1'($urandom);
            man_ack     = 1'($urandom);
            mem_ack_b   = 1'($urandom);
            mem_rdata_b = 8'($urandom);
            tick();
            check("rst_outs_a", outs_a(), 32'h0);
            check("rst_outs_b", outs_b(), 32'h0);
        end
        rx_valid_a = 1'b0;
        rx_valid_b = 1'b0;
        man_ack    = 1'b0;
        mem_ack_b  = 1'b0;
        rst        = 1'b0;
        tick();

        // Write then read back
        send_a(10'h02A);
        check("wa_idle", busy_a, 1'b0);
        send_a(10'h15C);
        check("wr_req", mem_req_a, 1'b1);
        check("wr_we", mem_we_a, 1'b1);
        check("wr_addr", mem_addr_a, 8'h2A);
        check("wr_wdata", mem_wdata_a, 8'h5C);
        check("wr_busy", busy_a, 1'b1);
        tick();
        tick();
        check("wr_done_req", mem_req_a, 1'b0);
        check("wr_done_busy", busy_a, 1'b0);
        send_a(10'h22A);
        send_a(10'h300);
        check("rd_req", mem_req_a, 1'b1);
        check("rd_we", mem_we_a, 1'b0);
        check("rd_addr", mem_addr_a, 8'h2A);
        tick();
        check("rd_tx_early", tx_valid_a, 1'b0);
        tick();
        check("rd_tx_valid", tx_valid_a, 1'b1);
        check("rd_tx_data", tx_data_a, 8'h5C);
        check("rd_req_low", mem_req_a, 1'b0);
        tick();
        check("rd_tx_pulse", tx_valid_a, 1'b0);

        // Auto-increment wrap on writes, increment on reads
        send_a(10'h0FF);
        send_a(10'h111);
        check("inc_addr0", mem_addr_a, 8'hFF);
        tick();
        tick();
        send_a(10'h122);
        check("inc_wrap", mem_addr_a, 8'h00);
        check("inc_wdata", mem_wdata_a, 8'h22);
        tick();
        tick();
        send_a(10'h300);
        check("inc_rd_addr", mem_addr_a, 8'h2B);
        tick();
        tick();
        tick();

        // Frame during an outstanding read is dropped
        ack_dly = 5;
        send_a(10'h200);
        send_a(10'h300);
        check("drop_req", mem_req_a, 1'b1);
        send_a(10'h1AA);
        check("drop_err", err_a, 1'b1);
        check("drop_req_held", mem_req_a, 1'b1);
        check("drop_addr_held", mem_addr_a, 8'h00);
        tick();
        check("drop_err_pulse", err_a, 1'b0);
        got_tx  = 1'b0;
        we_seen = 1'b0;
        rd      = 8'h00;
        for (int i = 0; i < 10 && !got_tx; i++) begin
            if (mem_req_a && mem_we_a) we_seen = 1'b1;
            if (tx_valid_a) begin
                got_tx = 1'b1;
                rd     = tx_data_a;
            end else begin
                tick();
            end
        end
        check("drop_tx_seen", got_tx, 1'b1);
        check("drop_tx_data", rd, 8'h22);
        check("drop_no_write", we_seen, 1'b0);
        tick();
        check("drop_req_after", mem_req_a, 1'b0);
        tick();
        check("drop_no_req2", mem_req_a, 1'b0);
        ack_dly = 0;

        // Timeout with ack withheld (instance b, TIMEOUT=4)
        send_b(10'h233);
        send_b(10'h300);
        for (int k = 1; k <= 4; k++) begin
            check("to_req_high", mem_req_b, 1'b1);
            check("to_err_low", err_b, 1'b0);
            tick();
        end
        check("to_req_low", mem_req_b, 1'b0);
        check("to_err", err_b, 1'b1);
        check("to_busy", busy_b, 1'b0);
        check("to_no_tx", tx_valid_b, 1'b0);
        tick();
        check("to_err_pulse", err_b, 1'b0);

        // Minimum latency read; rd_addr untouched by the abort
        send_b(10'h300);
        check("to_rd_addr", mem_addr_b, 8'h33);
        mem_ack_b   = 1'b1;
        mem_rdata_b = 8'h77;
        tick();
        mem_ack_b = 1'b0;
        check("minlat_tx", tx_valid_b, 1'b1);
        check("minlat_data", tx_data_b, 8'h77);
        tick();

        // Ack in the last allowed cycle is still a success
        send_b(10'h300);
        check("noinc_addr", mem_addr_b, 8'h33);
        tick();
        tick();
        tick();
        mem_ack_b   = 1'b1;
        mem_rdata_b = 8'h55;
        tick();
        mem_ack_b = 1'b0;
        check("late_ack_tx", tx_valid_b, 1'b1);
        check("late_ack_data", tx_data_b, 8'h55);
        check("late_ack_err", err_b, 1'b0);
        check("late_ack_busy", busy_b, 1'b0);
        tick();

        // Reset in the second request cycle
        ack_en = 1'b0;
        send_a(10'h300);
        check("mid_req1", mem_req_a, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_req_low", mem_req_a, 1'b0);
        check("mid_busy", busy_a, 1'b0);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("mid_no_tx", tx_valid_a, 1'b0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
